// File: rtl/pulse_channel_gen.sv
// pulse_channel_gen
//   Pulse-wave voice: phase accumulator, four selectable duty cycles, a
//   per-frame linear-decay envelope and a valid/ready note-load handshake.
//   The registered output is the compare value for a downstream PWM channel.
//
//   Optional feature macro: PULSE_CHANNEL_SWEEP_EN adds a per-frame
//   frequency sweep (i_sweep_shift / i_sweep_up ports).
//
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_note_valid    new note offered
//   o_note_ready    note can be accepted (accept = valid && ready)
//   i_phase_delta   per-cycle phase increment, sampled on accept
//   i_duty          00=12.5% 01=25% 10=50% 11=75%, sampled on accept
//   i_env_start     initial envelope level, sampled on accept
//   i_env_decay     frames per envelope decrement (0 = hold), sampled on accept
//   i_sweep_shift   sweep shift, 0 = no sweep (PULSE_CHANNEL_SWEEP_EN only)
//   i_sweep_up      sweep direction (PULSE_CHANNEL_SWEEP_EN only)
//   o_output        registered compare value
//   o_frame_pulse   one-cycle pulse aligned with phase 0 of each new period
//   o_active        high while a note is loading or playing
module pulse_channel_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 9,
    parameter int unsigned DIV_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_note_valid,
    output logic               o_note_ready,
    input  logic [PHASE_W-1:0] i_phase_delta,
    input  logic [1:0]         i_duty,
    input  logic [OUT_W-1:0]   i_env_start,
    input  logic [DIV_W-1:0]   i_env_decay,
`ifdef PULSE_CHANNEL_SWEEP_EN
    input  logic [2:0]         i_sweep_shift,
    input  logic               i_sweep_up,
`endif
    output logic [OUT_W-1:0]   o_output,
    output logic               o_frame_pulse,
    output logic               o_active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] delta_q, delta_d;
    logic [1:0]         duty_q, duty_d;
    logic [OUT_W-1:0]   env_q, env_d;
    logic [DIV_W-1:0]   decay_q, decay_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_pend_q, wrap_pend_d;
    logic               pulse_q;

    logic               accept;
    logic               carry;
    logic               wrap;
    logic               high;
    logic               note_end;
    logic [PHASE_W-1:0] sum;
    logic [2:0]         t;

`ifdef PULSE_CHANNEL_SWEEP_EN
    logic [2:0]         shift_q, shift_d;
    logic               up_q, up_d;
    logic [PHASE_W-1:0] sweep_step;
    logic [PHASE_W-1:0] sweep_delta;
    logic               sweep_end;

    always_comb begin
        sweep_step  = delta_q >> shift_q;
        sweep_delta = delta_q;
        sweep_end   = 1'b0;
        if (shift_q != 3'd0) begin
            if (up_q) begin
                {sweep_end, sweep_delta} = {1'b0, delta_q} + {1'b0, sweep_step};
            end else begin
                sweep_delta = delta_q - sweep_step;
                sweep_end   = (sweep_delta == '0);
            end
        end
    end
`endif

    assign o_note_ready     = !i_rst && (state_q != LOAD);
    assign accept           = i_note_valid && o_note_ready;
    assign {carry, sum}     = {1'b0, phase_q} + {1'b0, delta_q};
    assign wrap             = (state_q == PLAY) && carry;
    assign t                = phase_q[PHASE_W-1 -: 3];
    assign o_active         = (state_q == LOAD) || (state_q == PLAY);
    assign o_output         = out_q;
    assign o_frame_pulse    = pulse_q;

    always_comb begin
        high = 1'b0;
        case (duty_q)
            2'b00:   high = (t < 3'd1);
            2'b01:   high = (t < 3'd2);
            2'b10:   high = (t < 3'd4);
            default: high = (t < 3'd6);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        delta_d     = delta_q;
        duty_d      = duty_q;
        env_d       = env_q;
        decay_d     = decay_q;
        cnt_d       = cnt_q;
        wrap_pend_d = 1'b0;
        note_end    = 1'b0;
`ifdef PULSE_CHANNEL_SWEEP_EN
        shift_d     = shift_q;
        up_d        = up_q;
`endif

        case (state_q)
            IDLE: begin
                phase_d = '0;
            end
            LOAD: begin
                phase_d = '0;
                cnt_d   = '0;
                state_d = (env_q == '0) ? IDLE : PLAY;
            end
            PLAY: begin
                phase_d = sum;
                if (wrap) begin
                    if (decay_q != '0) begin
                        if (cnt_q == decay_q - DIV_W'(1)) begin
                            cnt_d = '0;
                            env_d = env_q - OUT_W'(1);
                            if (env_q == OUT_W'(1)) begin
                                note_end = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + DIV_W'(1);
                        end
                    end
`ifdef PULSE_CHANNEL_SWEEP_EN
                    delta_d = sweep_delta;
                    if (sweep_end) begin
                        note_end = 1'b1;
                    end
`endif
                    // A wrap that ends the note produces no pulse, unless a
                    // retrigger lands on the same edge: then the pulse stands.
                    wrap_pend_d = !note_end || accept;
                    if (note_end) begin
                        state_d = IDLE;
                        phase_d = '0;
                        env_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides whatever PLAY decided, discarding any pending step.
        if (accept) begin
            state_d = LOAD;
            phase_d = '0;
            cnt_d   = '0;
            delta_d = i_phase_delta;
            duty_d  = i_duty;
            env_d   = i_env_start;
            decay_d = i_env_decay;
`ifdef PULSE_CHANNEL_SWEEP_EN
            shift_d = i_sweep_shift;
            up_d    = i_sweep_up;
`endif
        end
    end

    assign out_d = ((state_q == PLAY) && high) ? env_q : '0;

    // The wrap is pipelined one extra stage so the frame pulse lines up with
    // the output sample of the new period's phase 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            delta_q     <= '0;
            duty_q      <= '0;
            env_q       <= '0;
            decay_q     <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            wrap_pend_q <= 1'b0;
            pulse_q     <= 1'b0;
`ifdef PULSE_CHANNEL_SWEEP_EN
            shift_q     <= '0;
            up_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            delta_q     <= delta_d;
            duty_q      <= duty_d;
            env_q       <= env_d;
            decay_q     <= decay_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            wrap_pend_q <= wrap_pend_d;
            pulse_q     <= wrap_pend_q;
`ifdef PULSE_CHANNEL_SWEEP_EN
            shift_q     <= shift_d;
            up_q        <= up_d;
`endif
        end
    end

endmodule

// File: tb/tb_pulse_channel_gen.sv
// tb_pulse_channel_gen
//   Self-checking bench for pulse_channel_gen (PHASE_W=8). Expected output,
//   frame pulse and activity are computed in closed form from the note
//   parameters: phase = k*delta mod 256, wraps = floor(k*delta/256),
//   level = start - floor(wraps/decay), note over once wraps >= start*decay.
module tb_pulse_channel_gen;

    localparam int unsigned PW = 8;
    localparam int unsigned OW = 9;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [PW-1:0] delta;
    logic [1:0]    duty;
    logic [OW-1:0] env_start;
    logic [DW-1:0] decay;
    logic [OW-1:0] out;
    logic          fp;
    logic          active;
`ifdef PULSE_CHANNEL_SWEEP_EN
    logic [2:0]    sshift;
    logic          sup;
`endif

    pulse_channel_gen #(
        .PHASE_W(PW),
        .OUT_W  (OW),
        .DIV_W  (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_note_valid (valid),
        .o_note_ready (ready),
        .i_phase_delta(delta),
        .i_duty       (duty),
        .i_env_start  (env_start),
        .i_env_decay  (decay),
`ifdef PULSE_CHANNEL_SWEEP_EN
        .i_sweep_shift(sshift),
        .i_sweep_up   (sup),
`endif
        .o_output     (out),
        .o_frame_pulse(fp),
        .o_active     (active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Current note as seen by the model; m_start = 0 means nothing playing.
    int m_d     = 0;
    int m_duty  = 0;
    int m_start = 0;
    int m_decay = 0;
    int m_last  = -1;

    function automatic int wraps(input int k);
        return (k * m_d) / 256;
    endfunction

    function automatic bit ended(input int k);
        if (m_start == 0) return 1'b1;
        if (m_decay == 0) return 1'b0;
        return wraps(k) >= m_start * m_decay;
    endfunction

    function automatic int exp_out(input int k);
        int thr;
        int lvl;
        if (ended(k)) return 0;
        case (m_duty)
            0:       thr = 1;
            1:       thr = 2;
            2:       thr = 4;
            default: thr = 6;
        endcase
        lvl = (m_decay == 0) ? m_start : m_start - wraps(k) / m_decay;
        return (((k * m_d) % 256) / 32 < thr) ? lvl : 0;
    endfunction

    function automatic int exp_pulse(input int k);
        if (k == 0 || ended(k)) return 0;
        return (wraps(k) != wraps(k - 1)) ? 1 : 0;
    endfunction

    // Offer a note right after an edge; the previous note (if any) is the one
    // being retriggered, so its last in-flight sample is checked on the
    // accept edge and its pending wrap on the LOAD edge.
    task automatic play(input int d, input int du, input int st, input int dc,
                        input int sh, input bit up, input int len, input string tag);
        int j;
        int pre_out;
        int pre_pulse;
        int load_pulse;
        j          = m_last;
        pre_out    = exp_out(j + 1);
        pre_pulse  = exp_pulse(j + 1);
        load_pulse = (!ended(j + 1) && wraps(j + 2) != wraps(j + 1)) ? 1 : 0;

        check({tag, ".rdy_pre"}, ready, 1);
        delta     = PW'(d);
        duty      = 2'(du);
        env_start = OW'(st);
        decay     = DW'(dc);
`ifdef PULSE_CHANNEL_SWEEP_EN
        sshift    = 3'(sh);
        sup       = up;
`else
        if (sh != 0 || up) $display("note: sweep args ignored in %s", tag);
`endif
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check({tag, ".acc_out"}, out, pre_out);
        check({tag, ".acc_fp"}, fp, pre_pulse);
        check({tag, ".load_rdy"}, ready, 0);
        check({tag, ".load_act"}, active, 1);

        m_d = d; m_duty = du; m_start = st; m_decay = dc;
        tick();
        check({tag, ".ld_out"}, out, 0);
        check({tag, ".ld_fp"}, fp, load_pulse);
        check({tag, ".ld_act"}, active, ended(0) ? 0 : 1);
        check({tag, ".ld_rdy"}, ready, 1);

        for (int k = 0; k < len; k++) begin
            tick();
            check($sformatf("%s.out[%0d]", tag, k), out, exp_out(k));
            check($sformatf("%s.fp[%0d]", tag, k), fp, exp_pulse(k));
            check($sformatf("%s.act[%0d]", tag, k), active, ended(k + 1) ? 0 : 1);
        end
        m_last = len - 1;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".rdy_in_rst"}, ready, 0);
        tick();
        rst = 1'b0;
        check({tag, ".out"}, out, 0);
        check({tag, ".fp"}, fp, 0);
        check({tag, ".act"}, active, 0);
        #1;
        check({tag, ".rdy_after"}, ready, 1);
        m_start = 0;
        m_last  = -1;
    endtask

    initial begin
        rst       = 1'b1;
        valid     = 1'b0;
        delta     = '0;
        duty      = '0;
        env_start = '0;
        decay     = '0;
`ifdef PULSE_CHANNEL_SWEEP_EN
        sshift    = '0;
        sup       = 1'b0;
`endif
        tick();
        tick();
        check("rst.out", out, 0);
        check("rst.fp", fp, 0);
        check("rst.act", active, 0);
        check("rst.rdy", ready, 0);
        rst = 1'b0;
        #1;
        check("rel.rdy", ready, 1);

        // 50% duty, held level: 7,7,7,7,0,0,0,0 with a pulse each period.
        play(32, 2, 7, 0, 0, 1'b0, 24, "d50");
        // Other duties, each retriggering the previous note.
        play(32, 0, 7, 0, 0, 1'b0, 16, "d12");
        play(32, 1, 7, 0, 0, 1'b0, 16, "d25");
        play(32, 3, 7, 0, 0, 1'b0, 16, "d75");
        // Reset mid-note.
        pulse_reset("rst_mid");
        // Linear decay: 5 down to 1, two frames each, then idle.
        play(32, 2, 5, 2, 0, 1'b0, 90, "decay");
        check("decay.end_out", out, 0);
        check("decay.end_act", active, 0);
        // Zero level: single LOAD cycle, nothing plays.
        play(32, 2, 0, 0, 0, 1'b0, 12, "zero");
        // Retrigger mid-play with level 3.
        play(40, 2, 9, 0, 0, 1'b0, 13, "pre");
        play(32, 1, 3, 0, 0, 1'b0, 16, "retrig");

`ifdef PULSE_CHANNEL_SWEEP_EN
        begin
            int eo[6] = '{7, 0, 7, 0, 0, 0};
            int ef[6] = '{0, 0, 1, 0, 0, 0};
            int ea[6] = '{1, 1, 1, 0, 0, 0};
            pulse_reset("sw_rst");
            delta = 8'd128; duty = 2'd2; env_start = 9'd7; decay = 8'd0;
            sshift = 3'd1; sup = 1'b1;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            tick();
            for (int k = 0; k < 6; k++) begin
                tick();
                check($sformatf("sweep.out[%0d]", k), out, eo[k]);
                check($sformatf("sweep.fp[%0d]", k), fp, ef[k]);
                check($sformatf("sweep.act[%0d]", k), active, ea[k]);
            end
            sshift = 3'd0; sup = 1'b0;
            m_start = 0;
            m_last  = -1;
        end
`endif

        // Randomised notes, mostly back-to-back retriggers.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) pulse_reset("rnd_rst");
            play($urandom_range(1, 255), $urandom_range(0, 3), $urandom_range(0, 12),
                 $urandom_range(0, 3), 0, 1'b0, $urandom_range(1, 50), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
